// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit owning HI/LO.
// Runs mult/multu/div/divu over a fixed cycle count, then commits.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] out
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_MTHI  = 4'd3;
    localparam logic [3:0] OP_MTLO  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_DIV   = 4'd7;
    localparam logic [3:0] OP_DIVU  = 4'd8;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    typedef enum logic [1:0] {
        K_MUL,
        K_MULU,
        K_DIV,
        K_DIVU
    } kind_t;

    state_t             r_state;
    state_t             w_nxt_state;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_nxt_cnt;
    logic [CW-1:0]      w_load_cnt;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    kind_t              r_kind;
    kind_t              w_kind;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic               w_is_md;
    logic               w_idle;
    logic               w_start;
    logic               w_done;
    logic               w_wr_res;
    logic               w_mthi;
    logic               w_mtlo;
    logic               w_is_div;
    logic [31:0]        w_divisor;

    logic signed [63:0] w_sa;
    logic signed [63:0] w_sbm;
    logic signed [63:0] w_sbd;
    logic signed [63:0] w_sp;
    logic signed [63:0] w_sq;
    logic signed [63:0] w_sr;
    logic [63:0]        w_up;
    logic [31:0]        w_uq;
    logic [31:0]        w_ur;
    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;
    logic               w_unused;

    // Decode of the incoming op
    always_comb begin
        w_is_md    = 1'b0;
        w_kind     = K_MUL;
        w_load_cnt = CW'(MULT_CYCLES);
        case (op)
            OP_MULT: begin
                w_is_md = 1'b1;
                w_kind  = K_MUL;
            end
            OP_MULTU: begin
                w_is_md = 1'b1;
                w_kind  = K_MULU;
            end
            OP_DIV: begin
                w_is_md    = 1'b1;
                w_kind     = K_DIV;
                w_load_cnt = CW'(DIV_CYCLES);
            end
            OP_DIVU: begin
                w_is_md    = 1'b1;
                w_kind     = K_DIVU;
                w_load_cnt = CW'(DIV_CYCLES);
            end
            default: ;
        endcase
    end

    assign w_idle  = (r_state == S_IDLE);
    assign w_start = en & w_idle & w_is_md;
    assign w_mthi  = en & w_idle & (op == OP_MTHI);
    assign w_mtlo  = en & w_idle & (op == OP_MTLO);

    // Next-state logic
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_nxt_state = S_RUN;
                    w_nxt_cnt   = w_load_cnt;
                end
            end
            S_RUN: begin
                if (r_cnt <= CW'(1)) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_cnt   = '0;
                    w_done      = 1'b1;
                end else begin
                    w_nxt_cnt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    // Zero divisor is swapped for 1 so the datapath never sees x/0;
    // the commit is suppressed in that case anyway.
    assign w_is_div  = (r_kind == K_DIV) | (r_kind == K_DIVU);
    assign w_divisor = (r_b == 32'd0) ? 32'd1 : r_b;

    assign w_sa  = {{32{r_a[31]}}, r_a};
    assign w_sbm = {{32{r_b[31]}}, r_b};
    assign w_sbd = {{32{w_divisor[31]}}, w_divisor};
    assign w_sp  = w_sa * w_sbm;
    assign w_up  = {32'd0, r_a} * {32'd0, r_b};
    assign w_sq  = w_sa / w_sbd;
    assign w_sr  = w_sa % w_sbd;
    assign w_uq  = r_a / w_divisor;
    assign w_ur  = r_a % w_divisor;

    assign w_unused = ^{w_sq[63:32], w_sr[63:32]};

    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        case (r_kind)
            K_MUL: begin
                w_res_hi = w_sp[63:32];
                w_res_lo = w_sp[31:0];
            end
            K_MULU: begin
                w_res_hi = w_up[63:32];
                w_res_lo = w_up[31:0];
            end
            K_DIV: begin
                w_res_hi = w_sr[31:0];
                w_res_lo = w_sq[31:0];
            end
            K_DIVU: begin
                w_res_hi = w_ur;
                w_res_lo = w_uq;
            end
            default: ;
        endcase
    end

    assign w_wr_res = w_done & ~(w_is_div & (r_b == 32'd0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_kind  <= K_MUL;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            if (w_start) begin
                r_a    <= a;
                r_b    <= b;
                r_kind <= w_kind;
            end
            if (w_wr_res) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else begin
                if (w_mthi) r_hi <= a;
                if (w_mtlo) r_lo <= a;
            end
        end
    end

    always_comb begin
        out = 32'd0;
        if (en) begin
            case (op)
                OP_MFHI: out = r_hi;
                OP_MFLO: out = r_lo;
                default: out = 32'd0;
            endcase
        end
    end

    assign start = w_start;
    assign busy  = (r_state == S_RUN);
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit.
// Expected HI/LO pairs are queued at issue and checked when busy drops.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        en;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] out;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] sbq[$];
    logic        prev_busy = 1'b0;

    md_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .op   (op),
        .a    (a),
        .b    (b),
        .start(start),
        .busy (busy),
        .hi   (hi),
        .lo   (lo),
        .out  (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Commit monitor: pops the oldest expectation when busy falls.
    always @(negedge clk) begin
        if (prev_busy && !busy && reset) begin
            if (sbq.size() == 0) begin
                check("sb_unexpected_commit", 32'd1, 32'd0);
            end else begin
                logic [63:0] e;
                e = sbq.pop_front();
                check("sb_hi", hi, e[63:32]);
                check("sb_lo", lo, e[31:0]);
            end
        end
        prev_busy = busy & reset;
    end

    task automatic wait_idle(input int c0, input int n, input string tag);
        int cnt;
        cnt = c0;
        while (busy && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, cnt, n);
    endtask

    task automatic run_md(input logic [3:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] eh,
                          input logic [31:0] el, input int n,
                          input string tag);
        @(negedge clk);
        en = 1'b1;
        op = o;
        a  = x;
        b  = y;
        #1;
        check({tag, "_start"}, {31'd0, start}, 32'd1);
        sbq.push_back({eh, el});
        @(negedge clk);
        en = 1'b0;
        op = 4'd0;
        a  = $urandom;
        b  = $urandom;
        #1;
        check({tag, "_start_drop"}, {31'd0, start}, 32'd0);
        wait_idle(0, n, tag);
    endtask

    task automatic wr(input logic [3:0] o, input logic [31:0] x);
        @(negedge clk);
        en = 1'b1;
        op = o;
        a  = x;
        @(negedge clk);
        en = 1'b0;
        op = 4'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        en    = 1'b0;
        op    = 4'd0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_start", {31'd0, start}, 32'd0);
        check("rst_out", out, 32'd0);
        reset = 1'b1;

        run_md(4'd1, 32'hFFFF_FFFD, 32'd5,
               32'hFFFF_FFFF, 32'hFFFF_FFF1, 5, "mult");
        run_md(4'd2, 32'hFFFF_FFFF, 32'd2,
               32'h0000_0001, 32'hFFFF_FFFE, 5, "multu");
        run_md(4'd7, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, "div");
        run_md(4'd8, 32'hFFFF_FFF9, 32'd2,
               32'h0000_0001, 32'h7FFF_FFFC, 10, "divu");
        run_md(4'd7, 32'd7, 32'hFFFF_FFFE,
               32'h0000_0001, 32'hFFFF_FFFD, 10, "div_negb");
        run_md(4'd7, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h8000_0000, 10, "div_ovf");
        run_md(4'd1, 32'h8000_0000, 32'h8000_0000,
               32'h4000_0000, 32'h0000_0000, 5, "mult_min");

        wr(4'd3, 32'h1234);
        wr(4'd4, 32'h5678);
        check("mthi", hi, 32'h1234);
        check("mtlo", lo, 32'h5678);
        en = 1'b1;
        op = 4'd5;
        #1;
        check("mfhi", out, 32'h1234);
        op = 4'd6;
        #1;
        check("mflo", out, 32'h5678);
        op = 4'd15;
        a  = 32'hFFFF_FFFF;
        #1;
        check("inv_out", out, 32'd0);
        check("inv_start", {31'd0, start}, 32'd0);
        @(negedge clk);
        en = 1'b0;
        op = 4'd0;
        check("inv_hi", hi, 32'h1234);
        check("inv_lo", lo, 32'h5678);

        run_md(4'd7, 32'd99, 32'd0,
               32'h1234, 32'h5678, 10, "div0");

        @(negedge clk);
        en = 1'b1;
        op = 4'd1;
        a  = 32'd7;
        b  = 32'd6;
        sbq.push_back({32'd0, 32'd42});
        @(negedge clk);
        op = 4'd3;
        a  = 32'hDEAD;
        #1;
        check("intr_mthi_start", {31'd0, start}, 32'd0);
        @(negedge clk);
        check("intr_hi_kept", hi, 32'h1234);
        op = 4'd1;
        a  = 32'd3;
        b  = 32'd3;
        #1;
        check("intr_mult_start", {31'd0, start}, 32'd0);
        @(negedge clk);
        en = 1'b0;
        op = 4'd0;
        wait_idle(2, 5, "intr");

        @(negedge clk);
        en = 1'b1;
        op = 4'd7;
        a  = 32'd100;
        b  = 32'd7;
        @(negedge clk);
        en = 1'b0;
        op = 4'd0;
        repeat (2) @(negedge clk);
        check("abort_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_hi_after", hi, 32'd0);
        check("abort_lo_after", lo, 32'd0);
        check("abort_busy_after", {31'd0, busy}, 32'd0);

        check("sb_drained", sbq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide execution unit in the E stage, sitting directly downstream of the instruction decoder.
- Consumes the decoder's 4-bit XALUOp code plus the two E-stage register operands.
- Owns the architectural HI/LO registers and runs multi-cycle mult/multu/div/divu.
- Drives a busy/start pair that the hazard unit uses to stall MD-class instructions, and returns the mfhi/mflo read value.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high after a mult/multu start (≥1).
- DIV_CYCLES, 10, cycles busy stays high after a div/divu start (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  E-stage instruction valid; low means bubble or flush, so op is ignored.
- op  input  4  decoder XALUOp code: 1 mult, 2 multu, 3 mthi, 4 mtlo, 5 mfhi, 6 mflo, 7 div, 8 divu; anything else is a no-op.
- a  input  32  rs operand.
- b  input  32  rt operand.
- start  output  1  combinational; en & !busy & op∈{1,2,7,8}.
- busy  output  1  registered; high while a multi-cycle operation is in flight.
- hi  output  32  current HI register.
- lo  output  32  current LO register.
- out  output  32  combinational; HI when op=5, LO when op=6, else 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - hi, lo, busy, cycle counter, operand/result temporaries all clear to 0.
  - Mid-operation: the operation is aborted and no HI/LO commit occurs after reset releases.
- Start, at the rising edge where start=1:
  - Latch a, b and op-kind.
  - Load counter = MULT_CYCLES (op 1,2) or DIV_CYCLES (op 7,8); set busy=1.
  - Operands may change on later cycles without effect.
- Busy phase:
  - Counter decrements each edge.
  - On the edge where the counter goes 1→0: commit result to HI/LO and clear busy.
  - busy is therefore high for exactly N cycles after the start edge.
  - The first cycle with busy=0 already shows the new hi/lo.
- Results:
  - mult: signed 32×32→64; HI=[63:32], LO=[31:0].
  - multu: unsigned 32×32→64; same split.
  - div: signed; LO=quotient truncated toward zero, HI=remainder with the dividend's sign.
  - divu: unsigned; LO=quotient, HI=remainder.
  - Divide by zero (b=0): run the full DIV_CYCLES, then HI/LO keep their previous values; no exception.
- mthi/mtlo:
  - When en & !busy, write a into HI (op 3) or LO (op 4) at the edge.
  - Ignored while busy.
- While busy:
  - Any op (start, mthi, mtlo) is ignored and internal state is unaffected.
  - The hazard unit must stall MD-class instructions while busy|start; a violation is silently dropped, never corrupting the in-flight result.
- mfhi/mflo: pure combinational read of the current registers; no side effects; valid regardless of busy. The hazard unit guarantees it is never issued while busy.
- Invalid op codes (0, 9–15) or en=0: no state change; out=0.
- State machine:
  - IDLE → RUN on start.
  - RUN → IDLE on counter 1→0 (commit).
  - Any state → IDLE on reset.
- Widths: all arithmetic is done at 64 bits internally; no overflow flags.

Test Plan:
- Reset release, then mult a=0xFFFFFFFD (−3), b=5 → busy high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- multu a=0xFFFFFFFF, b=2 → after 5 cycles hi=0x00000001, lo=0xFFFFFFFE; start high only in the issue cycle.
- div a=0xFFFFFFF9 (−7), b=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu with the same operands → lo=0x7FFFFFFC, hi=0x00000001.
- mthi a=0x1234 then mtlo a=0x5678 → hi=0x1234, lo=0x5678; mfhi out=0x1234, mflo out=0x5678. Then div with b=0 → busy 10 cycles, hi/lo unchanged.
- During a busy mult, drive mthi a=0xDEAD and a second mult → both ignored; the original product commits on schedule.
- Assert reset in busy cycle 3 of a div → hi=lo=0 and busy=0 immediately (asynchronous); no commit after reset releases.
